// File: rtl/sim_axil_mem_slave.sv
// AXI4-Lite memory responder for simulation: independent read/write FSMs with a fixed
// response latency and a word-addressed, byte-strobed backing array. Optional macro: AXIL_MEM_RANGE_ERR_EN.
module sim_axil_mem_slave #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter int unsigned       LATENCY     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAT_LAST = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_MEM_RANGE_ERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

`ifdef AXIL_MEM_RANGE_ERR_EN
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE_ADDR;
        return (off >> (IDX_W + 2)) == '0;
    endfunction
`endif

    // ---------------- read channel ----------------
    rd_state_e         rd_q, rd_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_load_c;

    always_comb begin
        rd_d      = rd_q;
        rd_cnt_d  = rd_cnt_q;
        rd_addr_d = rd_addr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_load_c = 1'b0;
        case (rd_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rd_addr_d = araddr;
                    arready_d = 1'b0;
                    rd_cnt_d  = '0;
                    if (LATENCY == 0) begin
                        rd_d      = R_RESP;
                        rd_load_c = 1'b1;
                    end else begin
                        rd_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == LAT_LAST) begin
                    rd_d      = R_RESP;
                    rd_load_c = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rvalid_q && rready) begin
                    rd_d      = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: rd_d = R_IDLE;
        endcase
        // Sample the array on the edge that enters R_RESP; a same-edge write is not yet visible.
        if (rd_load_c) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_q[word_idx(rd_addr_d)];
            rresp_d  = RESP_OKAY;
`ifdef AXIL_MEM_RANGE_ERR_EN
            if (!in_range(rd_addr_d)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q      <= R_IDLE;
            rd_cnt_q  <= '0;
            rd_addr_q <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            rd_q      <= rd_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_addr_q <= rd_addr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    wr_state_e         wr_q, wr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              wr_commit_c;
    logic              mem_we_c;

    always_comb begin
        wr_d        = wr_q;
        wr_cnt_d    = wr_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_strb_d   = wr_strb_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_commit_c = 1'b0;
        case (wr_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_done_d = 1'b1;
                    wr_addr_d = awaddr;
                    awready_d = 1'b0;
                end
                if (wvalid && wready_q) begin
                    w_done_d  = 1'b1;
                    wr_data_d = wdata;
                    wr_strb_d = wstrb;
                    wready_d  = 1'b0;
                end
                // Latency counts from whichever of AW/W completes last.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wr_cnt_d  = '0;
                    if (LATENCY == 0) begin
                        wr_d        = W_RESP;
                        wr_commit_c = 1'b1;
                    end else begin
                        wr_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == LAT_LAST) begin
                    wr_d        = W_RESP;
                    wr_commit_c = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    wr_d      = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wr_d = W_IDLE;
        endcase
        mem_we_c = wr_commit_c && reset;
        if (wr_commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
`ifdef AXIL_MEM_RANGE_ERR_EN
            if (!in_range(wr_addr_d)) begin
                bresp_d  = RESP_SLVERR;
                mem_we_c = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q      <= W_IDLE;
            wr_cnt_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            wr_q      <= wr_d;
            wr_cnt_q  <= wr_cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_strb_q <= wr_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Backing array keeps its contents across reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wr_strb_d[i]) begin
                    mem_q[word_idx(wr_addr_d)][8*i +: 8] <= wr_data_d[8*i +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_sim_axil_mem_slave.sv
// Bench for sim_axil_mem_slave: two instances (latency 2 and latency 0) share one stimulus bus;
// results are checked against an array model of the word memory.
module tb_sim_axil_mem_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic        a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
    logic [31:0] a_rdata;
    logic [1:0]  a_rresp, a_bresp;
    logic        z_arready, z_rvalid, z_awready, z_wready, z_bvalid;
    logic [31:0] z_rdata;
    logic [1:0]  z_rresp, z_bresp;

    logic        sel = 1'b0;
    logic        arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
    logic [31:0] rdata_m;
    logic [1:0]  rresp_m, bresp_m;
    assign arready_m = sel ? z_arready : a_arready;
    assign rvalid_m  = sel ? z_rvalid  : a_rvalid;
    assign awready_m = sel ? z_awready : a_awready;
    assign wready_m  = sel ? z_wready  : a_wready;
    assign bvalid_m  = sel ? z_bvalid  : a_bvalid;
    assign rdata_m   = sel ? z_rdata   : a_rdata;
    assign rresp_m   = sel ? z_rresp   : a_rresp;
    assign bresp_m   = sel ? z_bresp   : a_bresp;

    sim_axil_mem_slave #(.LATENCY(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(a_arready),
        .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(a_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(a_wready),
        .bresp(a_bresp), .bvalid(a_bvalid), .bready(bready)
    );

    sim_axil_mem_slave #(.LATENCY(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(z_arready),
        .rdata(z_rdata), .rresp(z_rresp), .rvalid(z_rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(z_awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(z_wready),
        .bresp(z_bresp), .bvalid(z_bvalid), .bready(bready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [31:0] model_mem [DEPTH];

    function automatic bit m_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(4 * DEPTH);
    endfunction

    function automatic int m_index(input logic [31:0] a);
        return int'(((a - BASE) / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
`ifdef AXIL_MEM_RANGE_ERR_EN
        return m_in_range(a) ? 2'b00 : 2'b10;
`else
        return 2'b00;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
        if (m_resp(a) == 2'b00)
            model_mem[m_index(a)] = (model_mem[m_index(a)] & ~mask) | (d & mask);
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        r = m_resp(a);
        d = (r == 2'b00) ? model_mem[m_index(a)] : 32'h0;
    endtask

    // ---------------- bus drivers (start and end on a falling edge) ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input int bhold,
                             output logic [1:0] resp, output int lat, output int held,
                             output bit ok, output bit wready_low);
        int  aw_start, w_start, k, aw_edge, w_edge, n;
        bit  aw_done, w_done;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; k = 0; aw_edge = 0; w_edge = 0;
        ok = 1; wready_low = 1; held = 0; resp = '0;
        awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
        while (!(aw_done && w_done) && k < 40) begin
            awvalid = !aw_done && (k >= aw_start);
            wvalid  = !w_done && (k >= w_start);
            if (w_done && wready_m) wready_low = 0;
            if (awvalid && awready_m) begin aw_done = 1; aw_edge = cyc + 1; end
            if (wvalid && wready_m) begin w_done = 1; w_edge = cyc + 1; end
            @(negedge clock); k++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) ok = 0;
        n = 0;
        while (!bvalid_m && n < 40) begin
            if (wready_m) wready_low = 0;
            @(negedge clock); n++;
        end
        if (!bvalid_m) ok = 0;
        lat  = cyc - ((aw_edge > w_edge) ? aw_edge : w_edge);
        resp = bresp_m;
        for (int i = 0; i < bhold; i++) begin
            if (bvalid_m && bresp_m == resp) held++;
            if (wready_m) wready_low = 0;
            @(negedge clock);
        end
        bready = 1'b1;
        if (bvalid_m && bresp_m == resp) held++;
        if (wready_m) wready_low = 0;
        @(negedge clock);
        bready = 1'b0;
        if (bvalid_m || !awready_m || !wready_m) ok = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output int held, output bit ok);
        int k, n, ar_edge;
        ok = 1; held = 0; k = 0; rready = 1'b0;
        araddr = a; arvalid = 1'b1;
        while (!arready_m && k < 40) begin @(negedge clock); k++; end
        if (!arready_m) ok = 0;
        ar_edge = cyc + 1;
        @(negedge clock);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid_m && n < 40) begin @(negedge clock); n++; end
        if (!rvalid_m) ok = 0;
        lat = cyc - ar_edge; data = rdata_m; resp = rresp_m;
        for (int i = 0; i < rhold; i++) begin
            if (rvalid_m && rdata_m == data && rresp_m == resp) held++;
            @(negedge clock);
        end
        rready = 1'b1;
        if (rvalid_m && rdata_m == data && rresp_m == resp) held++;
        @(negedge clock);
        rready = 1'b0;
        if (rvalid_m || !arready_m) ok = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit seen;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clock);
        n_checks++;
        if ({a_arready, a_awready, a_wready, a_rvalid, a_bvalid} !== 5'b11100) begin
            n_fail++; $display("FAIL reset_hold_hs: got %b expected 11100",
                               {a_arready, a_awready, a_wready, a_rvalid, a_bvalid});
        end
        n_checks++;
        if ({a_rdata, a_rresp, a_bresp} !== 36'h0) begin
            n_fail++; $display("FAIL reset_hold_data: got %h expected 0", {a_rdata, a_rresp, a_bresp});
        end
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({z_arready, z_awready, z_wready, z_rvalid, z_bvalid} !== 5'b11100) begin
            n_fail++; $display("FAIL reset_release: got %b expected 11100",
                               {z_arready, z_awready, z_wready, z_rvalid, z_bvalid});
        end
        araddr = BASE + 32'h40; arvalid = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        n_checks++;
        if ({a_arready, a_rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL rd_wait_entered: got %b expected 00", {a_arready, a_rvalid});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({a_arready, a_rvalid, z_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL rd_async_reset: got %b expected 100", {a_arready, a_rvalid, z_rvalid});
        end
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (a_rvalid || z_rvalid) seen = 1;
        end
        n_checks++;
        if (seen || !a_arready) begin
            n_fail++; $display("FAIL rd_dropped: got rvalid_seen=%0d arready=%0d expected 0 1", seen, a_arready);
        end
    endtask

    task automatic test_write_read();
        logic [1:0] r; logic [31:0] d, ed; logic [1:0] er; int lat, held; bit ok, wl;
        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat, held, ok, wl);
        model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        n_checks++;
        if (!ok || lat != LAT || r !== 2'b00) begin
            n_fail++; $display("FAIL wr_basic: got ok=%0d lat=%0d bresp=%0d expected 1 %0d 0", ok, lat, r, LAT);
        end
        axi_read(BASE + 32'h10, 0, d, r, lat, held, ok);
        model_read(BASE + 32'h10, ed, er);
        n_checks++;
        if (!ok || lat != LAT || d !== ed || r !== er) begin
            n_fail++; $display("FAIL rd_basic: got ok=%0d lat=%0d data=%h resp=%0d expected 1 %0d %h %0d",
                               ok, lat, d, r, LAT, ed, er);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] r; logic [31:0] d; int lat, held; bit ok, wl;
        axi_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 0, r, lat, held, ok, wl);
        model_write(BASE + 32'h20, 32'h1122_3344, 4'hF);
        axi_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, r, lat, held, ok, wl);
        model_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
        axi_read(BASE + 32'h20, 0, d, r, lat, held, ok);
        n_checks++;
        if (!ok || d !== 32'h11BB_33DD || r !== 2'b00) begin
            n_fail++; $display("FAIL strobes: got ok=%0d data=%h resp=%0d expected 1 11bb33dd 0", ok, d, r);
        end
        axi_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0, r, lat, held, ok, wl);
        axi_read(BASE + 32'h20, 0, d, r, lat, held, ok);
        n_checks++;
        if (!ok || d !== 32'h11BB_33DD) begin
            n_fail++; $display("FAIL strobe_zero: got ok=%0d data=%h expected 1 11bb33dd", ok, d);
        end
    endtask

    task automatic test_decoupled();
        logic [1:0] r; logic [31:0] d; int lat, held; bit ok, wl;
        axi_write(BASE + 32'h30, 32'h0F1E_2D3C, 4'hF, 3, 4, r, lat, held, ok, wl);
        model_write(BASE + 32'h30, 32'h0F1E_2D3C, 4'hF);
        n_checks++;
        if (!ok || lat != LAT || held != 5 || !wl || r !== 2'b00) begin
            n_fail++; $display("FAIL decoupled_b: got ok=%0d lat=%0d held=%0d wready_low=%0d bresp=%0d expected 1 %0d 5 1 0",
                               ok, lat, held, wl, r, LAT);
        end
        axi_read(BASE + 32'h30, 3, d, r, lat, held, ok);
        n_checks++;
        if (!ok || held != 4 || d !== 32'h0F1E_2D3C) begin
            n_fail++; $display("FAIL decoupled_r: got ok=%0d held=%0d data=%h expected 1 4 0f1e2d3c", ok, held, d);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] r, er; logic [31:0] d, ed; int lat, held; bit ok, wl;
        axi_write(BASE, 32'h0BAD_F00D, 4'hF, 0, 0, r, lat, held, ok, wl);
        model_write(BASE, 32'h0BAD_F00D, 4'hF);
        axi_write(BASE + 32'h4000, 32'h5555_5555, 4'hF, -1, 1, r, lat, held, ok, wl);
        model_write(BASE + 32'h4000, 32'h5555_5555, 4'hF);
        n_checks++;
        if (!ok || lat != LAT || r !== m_resp(BASE + 32'h4000)) begin
            n_fail++; $display("FAIL wrap_bresp: got ok=%0d lat=%0d bresp=%0d expected 1 %0d %0d",
                               ok, lat, r, LAT, m_resp(BASE + 32'h4000));
        end
        axi_read(BASE, 0, d, r, lat, held, ok);
        model_read(BASE, ed, er);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++; $display("FAIL wrap_word0: got ok=%0d data=%h resp=%0d expected 1 %h %0d", ok, d, r, ed, er);
        end
        axi_read(BASE + 32'h4000, 0, d, r, lat, held, ok);
        model_read(BASE + 32'h4000, ed, er);
        n_checks++;
        if (!ok || lat != LAT || d !== ed || r !== er) begin
            n_fail++; $display("FAIL wrap_alias: got ok=%0d lat=%0d data=%h resp=%0d expected 1 %0d %h %0d",
                               ok, lat, d, r, LAT, ed, er);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, er; logic [31:0] d, ed, a, wd; logic [3:0] s; int lat, held, hold, lead; bit ok, wl;
        for (int j = 0; j < 8; j++) begin
            wd = $urandom;
            axi_write(BASE + 32'(4 * (100 + j)), wd, 4'hF, 0, 0, r, lat, held, ok, wl);
            model_write(BASE + 32'(4 * (100 + j)), wd, 4'hF);
        end
        for (int it = 0; it < 30; it++) begin
            a = BASE + 32'(4 * (100 + $urandom_range(0, 7))) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a + 32'h4000 * 32'($urandom_range(1, 3));
            hold = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom; s = 4'($urandom_range(0, 15)); lead = $urandom_range(0, 4) - 2;
                axi_write(a, wd, s, lead, hold, r, lat, held, ok, wl);
                model_write(a, wd, s);
                n_checks++;
                if (!ok || lat != LAT || held != hold + 1 || r !== m_resp(a)) begin
                    n_fail++; $display("FAIL rand_wr @%h: got ok=%0d lat=%0d held=%0d bresp=%0d expected 1 %0d %0d %0d",
                                       a, ok, lat, held, r, LAT, hold + 1, m_resp(a));
                end
            end else begin
                axi_read(a, hold, d, r, lat, held, ok);
                model_read(a, ed, er);
                n_checks++;
                if (!ok || lat != LAT || held != hold + 1 || d !== ed || r !== er) begin
                    n_fail++; $display("FAIL rand_rd @%h: got ok=%0d lat=%0d held=%0d data=%h resp=%0d expected 1 %0d %0d %h %0d",
                                       a, ok, lat, held, d, r, LAT, hold + 1, ed, er);
                end
            end
        end
    endtask

    task automatic test_collision(input logic sel_v, input int exp_lat);
        logic [1:0] r, er; logic [31:0] d, ed; logic [31:0] a; int lat, held, n, hs; bit ok, wl, rdy;
        a = BASE + 32'h80;
        sel = sel_v;
        axi_write(a, 32'h0, 4'hF, 0, 0, r, lat, held, ok, wl);
        model_write(a, 32'h0, 4'hF);
        model_read(a, ed, er);
        araddr = a; awaddr = a; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        rdy = arready_m && awready_m && wready_m;
        hs = cyc + 1;
        @(negedge clock);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!(rvalid_m && bvalid_m) && n < 40) begin @(negedge clock); n++; end
        n_checks++;
        if (!rdy || !(rvalid_m && bvalid_m) || cyc - hs != exp_lat) begin
            n_fail++; $display("FAIL collide_timing sel=%0d: got rdy=%0d valids=%0d%0d lat=%0d expected 1 11 %0d",
                               sel_v, rdy, rvalid_m, bvalid_m, cyc - hs, exp_lat);
        end
        n_checks++;
        if (rdata_m !== ed || rresp_m !== er) begin
            n_fail++; $display("FAIL collide_old sel=%0d: got data=%h resp=%0d expected %h %0d",
                               sel_v, rdata_m, rresp_m, ed, er);
        end
        model_write(a, 32'hCAFE_F00D, 4'hF);
        rready = 1'b1; bready = 1'b1;
        @(negedge clock);
        rready = 1'b0; bready = 1'b0;
        axi_read(a, 0, d, r, lat, held, ok);
        model_read(a, ed, er);
        n_checks++;
        if (!ok || lat != exp_lat || d !== ed || r !== er) begin
            n_fail++; $display("FAIL collide_new sel=%0d: got ok=%0d lat=%0d data=%h expected 1 %0d %h",
                               sel_v, ok, lat, d, exp_lat, ed);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_decoupled();
        test_wrap();
        test_random();
        test_collision(1'b0, LAT);
        test_collision(1'b1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
